// File: rtl/counter_sequencer_if.sv
// Control/status bundle for counter_sequencer: configuration, run controls
// and the counter/status outputs, grouped so the controller and its user
// share a single port.
interface counter_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int WRAPW = 8
);
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_reload;
  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;
  logic [WRAPW-1:0] wraps;

  // The user side drives configuration and controls, and observes status.
  modport master (
    output cfg_we, cfg_limit, cfg_reload, start, pause, abort,
    input  count, busy, tc, done, wraps
  );

  // The controller side consumes controls and produces status.
  modport slave (
    input  cfg_we, cfg_limit, cfg_reload, start, pause, abort,
    output count, busy, tc, done, wraps
  );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer: sequences a WIDTH-bit up-counter through
// IDLE/RUN/HOLD/DONE. It uses a terminal value and a one-shot or
// auto-reload mode, both latched while idle. It emits a terminal-count
// pulse, a completion pulse and a saturating tally of reload periods.
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int WRAPW = 8
) (
  input logic              clk,
  input logic              rst,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic             reload_q;
  logic             tc_q;
  logic [WRAPW-1:0] wraps_q;

  logic             active;
  logic             step;
  logic             terminal;

  // A step happens in RUN or HOLD when neither abort nor pause holds it off.
  // A HOLD cycle with pause low therefore resumes counting on the same edge,
  // so P cycles of pause cost exactly P cycles of delay.
  always_comb begin
    active   = (state_q == S_RUN) || (state_q == S_HOLD);
    step     = active && !bus.abort && !bus.pause;
    terminal = step && (count_q == limit_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode, with abort taking priority over pause and over stepping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_RUN;
      S_RUN, S_HOLD: begin
        if (bus.abort)                  state_d = S_IDLE;
        else if (bus.pause)             state_d = S_HOLD;
        else if (terminal && !reload_q) state_d = S_DONE;
        else                            state_d = S_RUN;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state alone, plus the registered datapath values.
  always_comb begin
    bus.busy  = (state_q == S_RUN) || (state_q == S_HOLD);
    bus.done  = (state_q == S_DONE);
    bus.count = count_q;
    bus.tc    = tc_q;
    bus.wraps = wraps_q;
  end

  // Configuration is writable only while idle. A write in the start cycle
  // still lands before the run uses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      limit_q  <= '1;
      reload_q <= 1'b1;
    end else if (state_q == S_IDLE && bus.cfg_we) begin
      limit_q  <= bus.cfg_limit;
      reload_q <= bus.cfg_reload;
    end
  end

  // Counter datapath: cleared when idle or aborted. It advances on each step.
  // A terminal step reloads to zero or, in one-shot mode, holds at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case (state_q)
        S_RUN, S_HOLD: begin
          if (bus.abort)     count_q <= '0;
          else if (terminal) count_q <= reload_q ? '0 : count_q;
          else if (step)     count_q <= count_q + WIDTH'(1);
        end
        default: count_q <= '0;
      endcase
    end
  end

  // Terminal-count pulse, registered so it lines up with the reloaded count.
  always_ff @(posedge clk) begin
    if (rst) tc_q <= 1'b0;
    else     tc_q <= terminal;
  end

  // Reload-period tally: cleared on start, saturating at its maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      wraps_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      wraps_q <= '0;
    end else if (terminal && reload_q && (wraps_q != {WRAPW{1'b1}})) begin
      wraps_q <= wraps_q + WRAPW'(1);
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer: table-driven vectors whose expected
// outputs go through a scoreboard queue and are compared one cycle later,
// followed by hand-written boundary sequences.
module tb_counter_sequencer;
  localparam int WIDTH = 4;
  localparam int WRAPW = 8;

  logic clk = 1'b0;
  logic rst;

  counter_sequencer_if #(.WIDTH(WIDTH), .WRAPW(WRAPW)) bus ();

  counter_sequencer #(.WIDTH(WIDTH), .WRAPW(WRAPW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic             rst;
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_limit;
    logic             cfg_reload;
    logic             start;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;
    logic [WRAPW-1:0] wraps;
    logic             chk_wraps;
  } vec_t;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;
    logic [WRAPW-1:0] wraps;
    logic             chk_wraps;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(string tag, logic r, logic we, int lim, logic rel,
                              logic st, logic pa, logic ab, int cnt, logic by,
                              logic t, logic d, int w, logic cw);
    vec_t x;
    x.tag        = tag;
    x.rst        = r;
    x.cfg_we     = we;
    x.cfg_limit  = WIDTH'(lim);
    x.cfg_reload = rel;
    x.start      = st;
    x.pause      = pa;
    x.abort      = ab;
    x.count      = WIDTH'(cnt);
    x.busy       = by;
    x.tc         = t;
    x.done       = d;
    x.wraps      = WRAPW'(w);
    x.chk_wraps  = cw;
    return x;
  endfunction

  // Plain control step: no reset and no configuration write.
  function automatic void step(string tag, logic st, logic pa, logic ab, int cnt,
                               logic by, logic t, logic d, int w, logic cw);
    vecs.push_back(mk(tag, 1'b0, 1'b0, 0, 1'b0, st, pa, ab, cnt, by, t, d, w, cw));
  endfunction

  // Configuration write, optionally combined with start.
  function automatic void cfg(string tag, int lim, logic rel, logic st, int cnt,
                              logic by, int w, logic cw);
    vecs.push_back(mk(tag, 1'b0, 1'b1, lim, rel, st, 1'b0, 1'b0, cnt, by, 1'b0, 1'b0, w, cw));
  endfunction

  task automatic applyStimulus(input vec_t x);
    exp_t e;
    rst            = x.rst;
    bus.cfg_we     = x.cfg_we;
    bus.cfg_limit  = x.cfg_limit;
    bus.cfg_reload = x.cfg_reload;
    bus.start      = x.start;
    bus.pause      = x.pause;
    bus.abort      = x.abort;
    e.tag       = x.tag;
    e.count     = x.count;
    e.busy      = x.busy;
    e.tc        = x.tc;
    e.done      = x.done;
    e.wraps     = x.wraps;
    e.chk_wraps = x.chk_wraps;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got an output with no expected entry");
      return;
    end
    e = sb.pop_front();
    if (bus.count !== e.count || bus.busy !== e.busy || bus.tc !== e.tc ||
        bus.done !== e.done || (e.chk_wraps && bus.wraps !== e.wraps)) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got count=%0d busy=%0b tc=%0b done=%0b wraps=%0d, expected count=%0d busy=%0b tc=%0b done=%0b wraps=%0d%s",
               e.tag, $time, bus.count, bus.busy, bus.tc, bus.done, bus.wraps,
               e.count, e.busy, e.tc, e.done, e.wraps, e.chk_wraps ? "" : "(unchecked)");
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_limit = '0; bus.cfg_reload = 1'b0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;

    // Reset for three cycles, then default config: limit 15 with reload.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("reset", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
    step("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("default_start", 1, 0, 0, 0, 1, 0, 0, 0, 1);
    for (int n = 1; n <= 32; n++)
      step("default_run", 0, 0, 0, n % 16, 1, (n % 16) == 0, 0, n / 16, 1);
    step("default_abort", 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // One-shot with limit 5, then check that pause/abort are ignored in IDLE.
    cfg("oneshot_cfg", 5, 0, 0, 0, 0, 0, 0);
    step("oneshot_start", 1, 0, 0, 0, 1, 0, 0, 0, 1);
    for (int n = 1; n <= 5; n++)
      step("oneshot_run", 0, 0, 0, n, 1, 0, 0, 0, 1);
    step("oneshot_done", 0, 0, 0, 5, 0, 1, 1, 0, 1);
    step("oneshot_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("idle_ignore_pause_abort", 0, 1, 1, 0, 0, 0, 0, 0, 1);

    // Pause of 4 cycles at count 3 in a limit-9 reload run.
    cfg("pause_cfg", 9, 1, 0, 0, 0, 0, 1);
    step("pause_start", 1, 0, 0, 0, 1, 0, 0, 0, 1);
    for (int n = 1; n <= 3; n++)
      step("pause_run", 0, 0, 0, n, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      step("pause_hold", 0, 1, 0, 3, 1, 0, 0, 0, 1);
    step("pause_resume", 0, 0, 0, 4, 1, 0, 0, 0, 1);
    for (int n = 5; n <= 9; n++)
      step("pause_run_late", 0, 0, 0, n, 1, 0, 0, 0, 1);
    step("pause_tc_at_14", 0, 0, 0, 0, 1, 1, 0, 1, 1);
    step("pause_abort", 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Limit 12 run, with start and cfg_we at count 7 ignored, then abort.
    cfg("abort_cfg", 12, 1, 0, 0, 0, 0, 0);
    step("abort_start", 1, 0, 0, 0, 1, 0, 0, 0, 1);
    for (int n = 1; n <= 7; n++)
      step("abort_run", 0, 0, 0, n, 1, 0, 0, 0, 1);
    vecs.push_back(mk("ignored_cfg_start", 1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0, 0, 1'b1));
    for (int n = 9; n <= 27; n++)
      step("abort_run_period13", 0, 0, 0, n % 13, 1, (n % 13) == 0, 0, n / 13, 1);
    step("abort_mid_run", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("abort_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("restart_keeps_limit12", 1, 0, 0, 0, 1, 0, 0, 0, 1);
    for (int n = 1; n <= 13; n++)
      step("restart_run", 0, 0, 0, n % 13, 1, n == 13, 0, n / 13, 1);
    step("restart_abort", 0, 0, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Limit 0 with reload, written in the start cycle: tc continuous, wraps saturates.
    applyStimulus(mk("zero_cfg_start", 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b1));
    checkOutput();
    for (int n = 1; n <= 260; n++) begin
      applyStimulus(mk("zero_limit_run", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0,
                       (n > 255) ? 255 : n, 1'b1));
      checkOutput();
    end
    applyStimulus(mk("zero_abort", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0));
    checkOutput();

    // Reset mid-run restores outputs and the default limit of 15.
    applyStimulus(mk("rst_cfg_start", 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b1));
    checkOutput();
    for (int n = 1; n <= 2; n++) begin
      applyStimulus(mk("rst_pre_run", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, n, 1'b1, 1'b0, 1'b0, 0, 1'b1));
      checkOutput();
    end
    applyStimulus(mk("rst_mid_run", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
    checkOutput();
    applyStimulus(mk("rst_idle", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1));
    checkOutput();
    applyStimulus(mk("rst_restart", 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b1));
    checkOutput();
    for (int n = 1; n <= 16; n++) begin
      applyStimulus(mk("rst_default_limit", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, n % 16, 1'b1,
                       n == 16, 1'b0, n / 16, 1'b1));
      checkOutput();
    end

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard_leftover: got %0d pending entries, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Controller that owns and sequences a WIDTH-bit binary up-counter datapath. Software-style configuration (terminal value, one-shot vs auto-reload) is latched while idle. Start/pause/abort controls run the count, and the block emits terminal-count and completion pulses plus a saturating wrap tally. It sits above the free-running binary counters in the design and gives them controlled start/stop, programmable period and status.

## Interface
Parameters:
- WIDTH, 4, counter width in bits
- WRAPW, 8, width of saturating wrap tally

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write cfg_limit/cfg_reload; honoured only in IDLE
- cfg_limit  in  WIDTH  terminal count value L
- cfg_reload  in  1  1 = auto-reload, 0 = one-shot
- start  in  1  begin run; honoured only in IDLE
- pause  in  1  level; freezes count while high
- abort  in  1  return to IDLE immediately; highest priority
- count  out  WIDTH  current count
- busy  out  1  high in RUN or HOLD
- tc  out  1  one-cycle pulse per terminal step
- done  out  1  one-cycle pulse on one-shot completion
- wraps  out  WRAPW  completed reload periods since start, saturating

## Operation
- State machine: IDLE, RUN, HOLD, DONE. All outputs are registered or decoded from state only.
- Reset values: state IDLE, count 0, busy 0, tc 0, done 0, wraps 0, limit all-ones, reload 1.
- Priority within a cycle: rst > abort > pause > step.
- IDLE:
  - count held at 0.
  - cfg_we latches limit/reload.
  - start -> RUN with count 0 and wraps 0.
  - If cfg_we and start arrive in the same cycle, the new config is written and used for the run.
  - pause and abort have no effect.
- RUN, abort: -> IDLE, count 0, no tc/done.
- RUN, pause high: -> HOLD, count unchanged.
- RUN, normal step:
  - If count != L: count+1.
  - If count == L (terminal step): tc=1 next cycle.
    - reload=1: count <- 0, stay RUN, wraps+1 (saturates at 2^WRAPW-1).
    - reload=0: -> DONE, count holds L.
- HOLD:
  - abort -> IDLE, count 0.
  - pause low -> RUN; count resumes next cycle.
- DONE:
  - done=1 for exactly this cycle, count = L, busy 0.
  - Next cycle -> IDLE, count 0.
  - abort in DONE -> IDLE, same result.
- L = 0: every RUN step is terminal. With reload, count stays 0 and tc stays high continuously.
- cfg_we or start outside IDLE: ignored, with no side effects.
- Count never exceeds L. No overflow past 2^WIDTH-1 is possible.

## Timing
- start sampled at edge k: from k, busy=1 and count=0. count=n at edge k+n for n<=L.
- Terminal step at edge k+L+1:
  - reload: count=0 and tc=1 in the same cycle. Period = L+1 cycles per wrap.
  - one-shot: state DONE, done=1, tc=1, count=L, busy=0. At edge k+L+2: IDLE, count=0, done=0.
- Pause held for P cycles inside RUN delays all later events by exactly P cycles.
- abort at edge j: at j, busy=0 and count=0. A new start is accepted at j+1.
- rst mid-run: all outputs return to reset values at the next edge. Latched config also reverts to defaults.
- tc and done are never asserted for more than one cycle, except tc with L=0 in reload mode.

## Test plan
- Reset: hold rst 3 cycles, then release.
  - Expect count=0, busy=0, tc=0, done=0, wraps=0.
  - Then start with default config (WIDTH=4): count runs 0..15, 0, ...; tc pulses at count 0 every 16 cycles; wraps=1 after the first tc.
- One-shot: cfg_we with limit=5, reload=0, then start.
  - count 0,1,2,3,4,5 over six cycles, then DONE: done=1, tc=1, count=5 for one cycle.
  - Then count=0, busy=0.
- Pause: limit=9, reload=1, start; raise pause when count=3 and hold 4 cycles.
  - count stays 3 throughout; it is 4 one cycle after pause falls.
  - First tc arrives 14 cycles after start instead of 10.
- Abort and ignored inputs: limit=12 run; at count=7 pulse start and cfg_we with limit=2.
  - Run is unaffected; count reaches 12 and wraps with period 13.
  - Then abort: next cycle count=0, busy=0, no tc/done; a fresh start uses limit 12.
- Boundaries:
  - limit=0, reload=1: tc stays high every cycle and count stays 0. wraps saturates at 255 after 255 cycles and holds.
  - Assert rst mid-run: all outputs return to reset values at the next edge, and limit reverts to 15.
